// File: rtl/cpu_core_hs.sv
// Multi-cycle fetch/execute core with one shared req/ack memory port.
// Parametrised data/address width and register count; per-register flags, HALT, illegal-op pulse.
module cpu_core_hs #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                NREGS    = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic              illegal,
   output logic [ADDR_W-1:0] pc_out
);

   localparam int RIDX = $clog2(NREGS);
   localparam int XW   = (DATA_W > 32) ? DATA_W : 32;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, addr_nxt;
   logic [31:0]       instr, instr_nxt;
   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  flags;
   logic              req_nxt, we_nxt, halted_nxt, illegal_nxt;
   logic [DATA_W-1:0] wdata_nxt, rf_wdata, rv1, rv2, rvd;
   logic              rf_we, flag_we, flag_wdata;
   logic [DATA_W:0]   sum;
   logic [XW-1:0]     hi_tmp;

   logic [5:0]        op;
   logic [RIDX-1:0]   rs1, rs2, rd;
   logic              hl;
   logic [15:0]       imm;

   assign op     = instr[5:0];
   assign rs1    = instr[6 +: RIDX];
   assign rs2    = instr[9 +: RIDX];
   assign rd     = instr[12 +: RIDX];
   assign hl     = instr[15];
   assign imm    = instr[31:16];
   assign rv1    = regs[rs1];
   assign rv2    = regs[rs2];
   assign rvd    = regs[rd];
   assign pc_inc = pc + ADDR_W'(1);
   assign pc_out = pc;

   // Handshake: a request is mem_req=1 with addr/we/wdata held constant; it completes on
   // the rising edge where mem_ack=1, and mem_req is always low for the cycle after that.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      instr_nxt   = instr;
      req_nxt     = mem_req;
      we_nxt      = mem_we;
      addr_nxt    = mem_addr;
      wdata_nxt   = mem_wdata;
      halted_nxt  = halted;
      illegal_nxt = 1'b0;
      rf_we       = 1'b0;
      rf_wdata    = '0;
      flag_we     = 1'b0;
      flag_wdata  = 1'b0;
      sum         = '0;
      hi_tmp      = '0;
      case (state)
         S_FETCH: begin
            if (!mem_req) begin
               req_nxt  = 1'b1;
               we_nxt   = 1'b0;
               addr_nxt = pc;
            end else if (mem_ack) begin
               instr_nxt = 32'(mem_rdata);
               req_nxt   = 1'b0;
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            state_nxt = S_FETCH;
            pc_nxt    = pc_inc;
            case (op)
               6'd0: ;
               6'd1, 6'd2: begin
                  sum        = (op == 6'd1) ? ({1'b0, rv1} + {1'b0, rv2})
                                            : ({1'b0, rv1} - {1'b0, rv2});
                  rf_we      = 1'b1;
                  rf_wdata   = sum[DATA_W-1:0];
                  flag_we    = 1'b1;
                  flag_wdata = sum[DATA_W];
               end
               6'd3, 6'd4, 6'd5: begin
                  rf_we      = 1'b1;
                  rf_wdata   = (op == 6'd3) ? (rv1 & rv2) : (op == 6'd4) ? (rv1 | rv2) : (rv1 ^ rv2);
                  flag_we    = 1'b1;
                  flag_wdata = (rf_wdata == '0);
               end
               6'd6: begin
                  rf_we = 1'b1;
                  if (hl) begin
                     // Upper-half load lands in bits 31:16 whatever DATA_W is; low half kept.
                     hi_tmp        = XW'(rvd);
                     hi_tmp[31:16] = imm;
                     rf_wdata      = hi_tmp[DATA_W-1:0];
                  end else begin
                     rf_wdata = DATA_W'(imm);
                  end
               end
               6'd7, 6'd8: begin
                  state_nxt = S_MEM;
                  pc_nxt    = pc;
                  we_nxt    = (op == 6'd7);
                  addr_nxt  = ADDR_W'(rv1);
                  wdata_nxt = (op == 6'd7) ? rv2 : mem_wdata;
               end
               6'd9:  pc_nxt = ADDR_W'(rv1);
               6'd10: if (flags[rs1]) pc_nxt = pc + ADDR_W'($signed(imm));
               6'd63: begin
                  state_nxt  = S_HALT;
                  pc_nxt     = pc;
                  halted_nxt = 1'b1;
               end
               default: illegal_nxt = 1'b1;
            endcase
            req_nxt = (state_nxt != S_HALT);
            if (state_nxt == S_FETCH) begin
               we_nxt   = 1'b0;
               addr_nxt = pc_nxt;
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               pc_nxt    = pc_inc;
               state_nxt = S_FETCH;
               if (!mem_we) begin
                  rf_we    = 1'b1;
                  rf_wdata = mem_rdata;
               end
            end
         end
         default: req_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         instr     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         halted    <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         instr     <= instr_nxt;
         mem_req   <= req_nxt;
         mem_we    <= we_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         halted    <= halted_nxt;
         illegal   <= illegal_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         flags <= '0;
      end else begin
         if (rf_we)   regs[rd]  <= rf_wdata;
         if (flag_we) flags[rd] <= flag_wdata;
      end
   end

endmodule

// File: tb/tb_cpu_core_hs.sv
// Directed bench for cpu_core_hs: a small program run against a wait-state memory model,
// with read/store scoreboards, startup timing, halt/illegal and async-reset checks.
module tb_cpu_core_hs;

   logic        clock, reset;
   logic        mem_req, mem_we, mem_ack, halted, illegal;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

   cpu_core_hs dut (
      .clock(clock), .reset(reset),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .halted(halted), .illegal(illegal), .pc_out(pc_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] enc(input logic [5:0] op, input int rd, input int rs1,
                                       input int rs2, input logic hl, input logic [15:0] imm);
      enc = {imm, hl, 3'(rd), 3'(rs2), 3'(rs1), op};
   endfunction

   logic [31:0] mem [64];
   logic [31:0] exp_rd_q[$];
   logic [63:0] exp_st_q[$];
   int          rd_wait, st_wait, cnt, ill_cnt;
   logic        sb_on, st_moved;
   logic [31:0] cap_addr, cap_data, cap_pc;

   // Memory responder: acks after the configured number of wait cycles and scoreboards each transfer.
   initial begin
      logic [63:0] e;
      mem_ack = 1'b0; mem_rdata = '0; cnt = 0; st_moved = 1'b0;
      cap_addr = '0; cap_data = '0; cap_pc = '0;
      forever begin
         @(negedge clock);
         if (!reset || !mem_req) begin
            mem_ack = 1'b0;
            cnt = 0;
         end else begin
            if (mem_ack) cnt = 0;
            if (mem_we) begin
               if (cnt == 0) begin
                  cap_addr = mem_addr; cap_data = mem_wdata; cap_pc = pc_out; st_moved = 1'b0;
               end else if (mem_addr !== cap_addr || mem_wdata !== cap_data || pc_out !== cap_pc) begin
                  st_moved = 1'b1;
               end
            end
            if (cnt == (mem_we ? st_wait : rd_wait)) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  if (sb_on) begin
                     check_eq("st_stable", st_moved, 1'b0);
                     check_eq("st_pending", exp_st_q.size() != 0, 1'b1);
                     if (exp_st_q.size() != 0) begin
                        e = exp_st_q.pop_front();
                        check_eq("st_addr", mem_addr, e[63:32]);
                        check_eq("st_data", mem_wdata, e[31:0]);
                     end
                  end
               end else begin
                  mem_rdata = mem[mem_addr[5:0]];
                  if (sb_on) begin
                     check_eq("rd_pending", exp_rd_q.size() != 0, 1'b1);
                     if (exp_rd_q.size() != 0) check_eq("rd_addr", mem_addr, exp_rd_q.pop_front());
                  end
               end
            end else begin
               mem_ack = 1'b0;
               cnt++;
            end
         end
      end
   end

   initial begin
      ill_cnt = 0;
      forever begin
         @(negedge clock);
         if (illegal) ill_cnt++;
      end
   end

   initial begin
      int req_cnt;
      reset = 1'b0; rd_wait = 0; st_wait = 3; sb_on = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0]  = enc(6'd6, 1, 0, 0, 1'b0, 16'hFFFF);   // LDI r1,0xFFFF
      mem[1]  = enc(6'd6, 2, 0, 0, 1'b0, 16'h0001);   // LDI r2,1
      mem[2]  = enc(6'd1, 3, 1, 2, 1'b0, 16'h0);      // ADD r3=r1+r2
      mem[3]  = enc(6'd2, 7, 7, 2, 1'b0, 16'h0);      // SUB r7=r7-r2
      mem[5]  = enc(6'd10, 0, 7, 0, 1'b0, 16'hFFFE);  // BF f7,-2
      mem[6]  = enc(6'd7, 0, 1, 2, 1'b0, 16'h0);      // ST [r1],r2
      mem[7]  = enc(6'd7, 0, 0, 3, 1'b0, 16'h0);      // ST [r0],r3
      mem[8]  = enc(6'd6, 5, 0, 0, 1'b1, 16'hFFFF);   // LDI.hi r5
      mem[9]  = enc(6'd1, 6, 5, 5, 1'b0, 16'h0);      // ADD r6=r5+r5 (carry)
      mem[10] = enc(6'd7, 0, 0, 6, 1'b0, 16'h0);      // ST [r0],r6
      mem[11] = enc(6'd6, 4, 0, 0, 1'b0, 16'h0020);   // LDI r4,32
      mem[12] = enc(6'd8, 5, 4, 0, 1'b0, 16'h0);      // LD r5,[r4]
      mem[13] = enc(6'd3, 3, 5, 1, 1'b0, 16'h0);      // AND r3=r5&r1
      mem[14] = enc(6'd7, 0, 0, 3, 1'b0, 16'h0);      // ST [r0],r3
      mem[15] = enc(6'd5, 4, 5, 5, 1'b0, 16'h0);      // XOR r4=r5^r5 (zero)
      mem[16] = enc(6'd10, 0, 6, 0, 1'b0, 16'h0002);  // BF f6,+2
      mem[18] = enc(6'd10, 0, 4, 0, 1'b0, 16'h0002);  // BF f4,+2
      mem[20] = enc(6'd4, 2, 2, 1, 1'b0, 16'h0);      // OR r2=r2|r1
      mem[21] = enc(6'd7, 0, 0, 2, 1'b0, 16'h0);      // ST [r0],r2
      mem[22] = enc(6'd6, 2, 0, 0, 1'b1, 16'h00AB);   // LDI.hi r2,0xAB
      mem[23] = enc(6'd7, 0, 0, 2, 1'b0, 16'h0);      // ST [r0],r2
      mem[24] = enc(6'd6, 4, 0, 0, 1'b0, 16'd30);     // LDI r4,30
      mem[25] = enc(6'd9, 0, 4, 0, 1'b0, 16'h0);      // JMP r4
      foreach (mem[i]) if (i == 17 || i == 19 || (i >= 26 && i <= 29)) mem[i] = enc(6'd7, 0, 0, 2, 1'b0, 16'h0);
      mem[30] = enc(6'h2A, 0, 0, 0, 1'b0, 16'h0);     // undefined opcode
      mem[31] = enc(6'd63, 0, 0, 0, 1'b0, 16'h0);     // HALT
      mem[32] = 32'hA5A5_1234;
      exp_rd_q = '{0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 32, 13, 14, 15, 16,
                   18, 20, 21, 22, 23, 24, 25, 30, 31};
      exp_st_q = '{{32'h0000_FFFF, 32'h0000_0001}, {32'h0, 32'h0001_0000}, {32'h0, 32'hFFFE_0000},
                   {32'h0, 32'h0000_1234}, {32'h0, 32'h0000_FFFF}, {32'h0, 32'h00AB_FFFF}};

      repeat (3) @(negedge clock);
      check_eq("rst_req", mem_req, 1'b0);
      check_eq("rst_we", mem_we, 1'b0);
      check_eq("rst_addr", mem_addr, 32'h0);
      check_eq("rst_wdata", mem_wdata, 32'h0);
      check_eq("rst_halted", halted, 1'b0);
      check_eq("rst_illegal", illegal, 1'b0);
      check_eq("rst_pc", pc_out, 32'h0);

      reset = 1'b1;
      #1 check_eq("req_before_clk", mem_req, 1'b0);
      @(posedge clock); #1;
      check_eq("req_cycle1", mem_req, 1'b1);
      check_eq("addr_cycle1", mem_addr, 32'h0);
      check_eq("we_cycle1", mem_we, 1'b0);
      @(posedge clock); #1 check_eq("req_drop_after_ack", mem_req, 1'b0);
      @(posedge clock); #1;
      check_eq("req_cycle3", mem_req, 1'b1);
      check_eq("addr_cycle3", mem_addr, 32'h1);

      for (int i = 0; i < 600 && !halted; i++) @(negedge clock);
      check_eq("halt_reached", halted, 1'b1);
      req_cnt = 0;
      repeat (5) begin
         @(negedge clock);
         if (mem_req) req_cnt++;
      end
      check_eq("halt_req_low", req_cnt, 0);
      check_eq("halt_pc", pc_out, 32'd31);
      check_eq("illegal_pulses", ill_cnt, 1);
      check_eq("rd_q_drained", exp_rd_q.size(), 0);
      check_eq("st_q_drained", exp_st_q.size(), 0);

      sb_on = 1'b0;
      rd_wait = 5;
      reset = 1'b0;
      @(negedge clock);
      check_eq("halt_cleared", halted, 1'b0);
      reset = 1'b1;
      @(posedge clock); #1 check_eq("refetch_req", mem_req, 1'b1);
      @(negedge clock);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check_eq("async_req_drop", mem_req, 1'b0);
      check_eq("async_pc", pc_out, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check_eq("restart_req", mem_req, 1'b1);
      check_eq("restart_addr", mem_addr, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
